mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage, directly downstream of the EXE->MEM register. Takes one held instruction,
//  issues at most one data-SRAM request (req/addr_ok/data_ok), aligns and extends load data,
//  and drives the MEM->WB register. Also produces stall/allowin and forwarding info for hazard logic.
// PARAMETERS
//  ADDR_W  32  data address width
//  DATA_W  32  data bus width; fixed at 32, because the byte-lane logic assumes 4 lanes
// PORTS
//  clk                     in   1   sole clock, rising edge
//  rst_n                   in   1   asynchronous, active-low reset
//  ms_in_valid             in   1   EXE->MEM register holds a valid instruction
//  mem_ref_we              in   1   instruction writes the register file
//  mem_alu_result          in   32  ALU result; written back when not a load
//  mem_dram_re/mem_dram_we in   1   load / store
//  mem_dram_waddr          in   32  effective address, used for loads and stores
//  mem_dram_wdata          in   32  store data, right-aligned
//  mem_rd / mem_pc         in   5/32 destination register / PC
//  mem_rdram_num           in   2   load size: 00 byte, 01 half, 10 word
//  mem_rdram_need_signed_extend / _zero_extend  in 1  load extension select
//  mem_wdram_num           in   2   store size, same encoding as mem_rdram_num
//  wb_allowin              in   1   WB stage can accept
//  ms_allowin              out  1   ms_in_valid may advance into this stage
//  ds_req / ds_wr          out  1   data-SRAM request / write
//  ds_size                 out  2   00 byte, 01 half, 10 word
//  ds_addr / ds_wdata      out  32  request address (low 2 bits cleared) / lane-replicated data
//  ds_wstrb                out  4   byte strobes
//  ds_addr_ok / ds_data_ok in   1   address accepted / data returned
//  ds_rdata                in   32  read data
//  wb_valid, wb_pc, wb_rd, wb_we, wb_wdata  out 1/32/5/1/32  MEM->WB register outputs
//  ms_fwd_rd / ms_fwd_busy out  5/1 forwarding target; busy=1 while a load result is not yet available
//  ms_ale                  out  1   pulse: misaligned access detected
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM=IDLE; all outputs 0; ms_allowin=1.
//  - FSM: IDLE -> REQ (valid load/store, aligned) -> WAIT (on ds_addr_ok) -> DONE (on ds_data_ok)
//    -> IDLE (when wb_allowin). Instructions that do not access memory: ready_go in IDLE, so latency is 1 cycle.
//  - Handshake: ds_req stays high in REQ until ds_addr_ok. If addr_ok and data_ok arrive in the
//    same cycle, go straight to DONE. Request fields stay stable while ds_req=1.
//  - ready_go = IDLE&&!mem || DONE || misaligned. ms_allowin = !held || (ready_go && wb_allowin).
//    DONE stalls while wb_allowin=0 and keeps the rdata it captured.
//  - Alignment: half with addr[0]=1, or word with addr[1:0]!=0, is misaligned. ms_ale pulses 1 cycle,
//    no request is issued, and the instruction reaches WB with wb_we=0.
//  - Store strobes: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'hF.
//    wdata is replicated: byte x4, half x2.
//  - Load: select byte/half by addr[1:0], then extend: signed if _signed_extend, else zero.
//    If both extend flags are 0, treat as word. Data is captured on data_ok, not re-sampled.
//  - WB register: loads when ready_go && wb_allowin. wb_valid clears when the next stage takes the
//    instruction and no new one follows. wb_wdata = loaded value for loads, else mem_alu_result.
//  - Forwarding: ms_fwd_rd = rd if held && mem_ref_we, else 0. ms_fwd_busy = held load not yet in DONE.
//  - Reset while in REQ/WAIT: abandon the request. The SRAM side must tolerate a dropped request.
// STRUCTURE
//  - Shared pkg: size encodings (SZ_B/H/W), FSM state encodings.
//  - Sub-module: load_align_ext (addr[1:0], size, signed, rdata -> 32b result), pure combinational.
// TESTING
//  1 ALU op, rd=5, alu=0x1234, wb_allowin=1 -> wb_valid=1, wb_wdata=0x1234 next cycle; no ds_req.
//  2 lb addr=0x1003, signed, rdata=0x80xxxxxx, addr_ok +1 cycle, data_ok +2 cycles -> wb_wdata=0xFFFFFF80.
//  3 sh addr=0x2002, wdata=0xABCD -> ds_wstrb=4'b1100, ds_wdata=0xABCDABCD, ds_size=01, ds_addr=0x2000.
//  4 lw addr=0x1002 -> ms_ale=1, ds_req never asserted, wb_we=0.
//  5 lhu returns data_ok while wb_allowin=0 for 3 cycles -> stays in DONE, ms_allowin=0,
//    fwd_busy=0; then wb_wdata=zero-extended half.
//  6 rst_n low mid-WAIT -> immediate IDLE, wb_valid=0, ds_req=0, ms_allowin=1.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes and FSM states.
package mem_access_stage_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } ms_state_e;

endpackage

// File: rtl/mem_access_stage_load_align_ext.sv
// Picks the addressed byte/half out of a 32-bit read word and extends it.
module load_align_ext
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  // Lane select then sign/zero extension; anything not byte/half passes the word through.
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    b       = shifted[7:0];
    h       = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    result = sign_ext ? {{24{b[7]}}, b} : {24'd0, b};
      SZ_H:    result = sign_ext ? {{16{h[15]}}, h} : {16'd0, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one data-SRAM transaction per held instruction,
// load alignment, MEM->WB register, stall and forwarding info.
//
// state | meaning
// IDLE  | no request outstanding; non-memory ops complete here
// REQ   | ds_req high, waiting for ds_addr_ok
// WAIT  | address accepted, waiting for ds_data_ok
// DONE  | transaction finished (load data held), waiting for wb_allowin
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ms_in_valid,
  input  logic              mem_ref_we,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              mem_dram_re,
  input  logic              mem_dram_we,
  input  logic [ADDR_W-1:0] mem_dram_waddr,
  input  logic [DATA_W-1:0] mem_dram_wdata,
  input  logic [4:0]        mem_rd,
  input  logic [31:0]       mem_pc,
  input  logic [1:0]        mem_rdram_num,
  input  logic              mem_rdram_need_signed_extend,
  input  logic              mem_rdram_need_zero_extend,
  input  logic [1:0]        mem_wdram_num,
  input  logic              wb_allowin,
  output logic              ms_allowin,
  output logic              ds_req,
  output logic              ds_wr,
  output logic [1:0]        ds_size,
  output logic [ADDR_W-1:0] ds_addr,
  output logic [DATA_W-1:0] ds_wdata,
  output logic [3:0]        ds_wstrb,
  input  logic              ds_addr_ok,
  input  logic              ds_data_ok,
  input  logic [DATA_W-1:0] ds_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_pc,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [4:0]        ms_fwd_rd,
  output logic              ms_fwd_busy,
  output logic              ms_ale
);

  ms_state_e         state;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ld_value;
  logic              is_load, is_store, is_mem;
  logic [1:0]        ld_size, acc_size, a_lo;
  logic              misaligned, ready_go, wb_take;
  logic [3:0]        st_strb;
  logic [DATA_W-1:0] st_wdata;

  assign a_lo     = mem_dram_waddr[1:0];
  assign is_load  = ms_in_valid && mem_dram_re;
  // A load flag wins if both are set, so a store is only a pure write.
  assign is_store = ms_in_valid && mem_dram_we && !mem_dram_re;
  assign is_mem   = is_load || is_store;
  // No extension requested means a full-word load.
  assign ld_size  = (!mem_rdram_need_signed_extend && !mem_rdram_need_zero_extend) ? SZ_W : mem_rdram_num;
  assign acc_size = mem_dram_re ? ld_size : mem_wdram_num;

  // Misalignment, ready_go and the allowin handshake.
  always_comb begin
    misaligned = 1'b0;
    if (is_mem) begin
      if (acc_size == SZ_H)      misaligned = a_lo[0];
      else if (acc_size != SZ_B) misaligned = (a_lo != 2'b00);
    end
    ready_go   = (state == ST_IDLE && !is_mem) || (state == ST_DONE) || misaligned;
    ms_allowin = !ms_in_valid || (ready_go && wb_allowin);
    wb_take    = ms_in_valid && ready_go && wb_allowin;
  end

  // Store byte strobes and lane-replicated write data.
  always_comb begin
    case (mem_wdram_num)
      SZ_B: begin
        st_strb  = 4'b0001 << a_lo;
        st_wdata = {4{mem_dram_wdata[7:0]}};
      end
      SZ_H: begin
        st_strb  = 4'b0011 << {a_lo[1], 1'b0};
        st_wdata = {2{mem_dram_wdata[15:0]}};
      end
      default: begin
        st_strb  = 4'hF;
        st_wdata = mem_dram_wdata;
      end
    endcase
  end

  load_align_ext u_align (
    .addr_lo  (a_lo),
    .size     (ld_size),
    .sign_ext (mem_rdram_need_signed_extend),
    .rdata    (rdata_q),
    .result   (ld_value)
  );

  // Request FSM; request fields are registered on entry to REQ and held until addr_ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ds_req   <= 1'b0;
      ds_wr    <= 1'b0;
      ds_size  <= 2'b00;
      ds_addr  <= '0;
      ds_wdata <= '0;
      ds_wstrb <= 4'h0;
      rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem && !misaligned) begin
            state    <= ST_REQ;
            ds_req   <= 1'b1;
            ds_wr    <= is_store;
            ds_size  <= acc_size;
            ds_addr  <= {mem_dram_waddr[ADDR_W-1:2], 2'b00};
            ds_wdata <= is_store ? st_wdata : '0;
            ds_wstrb <= is_store ? st_strb : 4'h0;
          end
        end
        ST_REQ: begin
          if (ds_addr_ok) begin
            ds_req <= 1'b0;
            if (ds_data_ok) begin
              state   <= ST_DONE;
              rdata_q <= ds_rdata;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (ds_data_ok) begin
            state   <= ST_DONE;
            rdata_q <= ds_rdata;
          end
        end
        ST_DONE: begin
          if (wb_allowin) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MEM->WB register and the misaligned-access pulse that travels with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_pc    <= '0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
      wb_wdata <= '0;
      ms_ale   <= 1'b0;
    end else if (wb_take) begin
      wb_valid <= 1'b1;
      wb_pc    <= mem_pc;
      wb_rd    <= mem_rd;
      wb_we    <= mem_ref_we && !misaligned;
      wb_wdata <= (is_load && !misaligned) ? ld_value : mem_alu_result;
      ms_ale   <= misaligned;
    end else begin
      ms_ale <= 1'b0;
      if (wb_allowin) wb_valid <= 1'b0;
    end
  end

  assign ms_fwd_rd   = (ms_in_valid && mem_ref_we && !misaligned) ? mem_rd : 5'd0;
  assign ms_fwd_busy = is_load && !misaligned && (state != ST_DONE);

endmodule
